fsk_top: RTL and testbench



---
 rtl/fsk_top.sv | 159 +++++++++++++++
 tb/tb_fsk_top.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fsk_top.sv
`timescale 1ns/100ps
// fsk_top: two-channel FSK modulator with a windowed edge-counting demodulator.
// The modulator gates one of two carriers onto modulator_out according to the
// data bits. The demodulator counts rising edges of the line and of each
// reference carrier over a fixed window, then reports the closer tone.
module fsk_top #(
  parameter int WIN = 16,  // decision window length in clk cycles (4..255)
  parameter int TOL = 1,   // max rising-edge count mismatch for a tone match
  parameter int CW  = 8    // edge-counter width, 2^CW > WIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data1,
  input  logic data2,
  input  logic f1,
  input  logic f2,
  output logic q1,
  output logic q2
);

  // Bit order in the synchronizer vectors: {data1, data2, f1, f2}.
  logic [3:0] sync_a;
  logic [3:0] sync_b;
  logic       data1_s;
  logic       data2_s;
  logic       f1_s;
  logic       f2_s;

  logic       modulator_out;

  logic       mod_d;
  logic       f1_d;
  logic       f2_d;
  logic       mod_rise;
  logic       f1_rise;
  logic       f2_rise;

  logic [7:0] win_cnt;
  logic       win_end;

  logic [CW-1:0] cm;
  logic [CW-1:0] c1;
  logic [CW-1:0] c2;
  logic [CW-1:0] cm_nx;
  logic [CW-1:0] c1_nx;
  logic [CW-1:0] c2_nx;
  logic [CW-1:0] d1;
  logic [CW-1:0] d2;
  logic          q1_nx;
  logic          q2_nx;

  // Unsigned distance between two counts; the subtraction order avoids wrap.
  function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a,
                                             input logic [CW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Saturating increment so a runaway carrier cannot wrap a count to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v,
                                            input logic          en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign data1_s = sync_b[3];
  assign data2_s = sync_b[2];
  assign f1_s    = sync_b[1];
  assign f2_s    = sync_b[0];

  // Two-flop synchronizers for all asynchronous inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {data1, data2, f1, f2};
      sync_b <= sync_a;
    end
  end

  // Registered modulator: data1 has priority over data2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       modulator_out <= 1'b0;
    else if (data1_s) modulator_out <= f1_s;
    else if (data2_s) modulator_out <= f2_s;
    else              modulator_out <= 1'b0;
  end

  // One-cycle delayed copies for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_d <= 1'b0;
      f1_d  <= 1'b0;
      f2_d  <= 1'b0;
    end else begin
      mod_d <= modulator_out;
      f1_d  <= f1_s;
      f2_d  <= f2_s;
    end
  end

  // Rising-edge pulses plus next counter values and the tone decision.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    mod_rise = 1'b0;
    f1_rise  = 1'b0;
    f2_rise  = 1'b0;
    mod_rise = modulator_out & ~mod_d;
    f1_rise  = f1_s & ~f1_d;
    f2_rise  = f2_s & ~f2_d;
    // An edge in the window-end cycle still belongs to the closing window.
    cm_nx = sat_inc(cm, mod_rise);
    c1_nx = sat_inc(c1, f1_rise);
    c2_nx = sat_inc(c2, f2_rise);
    d1    = abs_diff(cm_nx, c1_nx);
    d2    = abs_diff(cm_nx, c2_nx);
    // Ties go to q1, which also keeps q1 and q2 mutually exclusive.
    q1_nx = (cm_nx != '0) && (int'(d1) <= TOL) && (d1 <= d2);
    q2_nx = (cm_nx != '0) && (int'(d2) <= TOL) && (d2 < d1);
  end

  assign win_end = (win_cnt == 8'(WIN - 1));

  // Free-running window counter 0..WIN-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       win_cnt <= '0;
    else if (win_end) win_cnt <= '0;
    else              win_cnt <= win_cnt + 8'd1;
  end

  // Per-window edge counters, cleared after each window end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm <= '0;
      c1 <= '0;
      c2 <= '0;
    end else if (win_end) begin
      cm <= '0;
      c1 <= '0;
      c2 <= '0;
    end else begin
      cm <= cm_nx;
      c1 <= c1_nx;
      c2 <= c2_nx;
    end
  end

  // Decision outputs update only at window end and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else if (win_end) begin
      q1 <= q1_nx;
      q2 <= q2_nx;
    end
  end

endmodule

// File: tb/tb_fsk_top.sv
`timescale 1ns/100ps
// tb_fsk_top: scoreboard bench for fsk_top. Expected tone decisions are queued
// against the window index in which they must appear; a monitor on the falling
// clock edge pops and compares them, and tracks a reference modulator model.
module tb_fsk_top;

  localparam int WIN = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic data1 = 1'b0;
  logic data2 = 1'b0;
  logic f1    = 1'b0;
  logic f2    = 1'b0;
  logic q1;
  logic q2;

  int n_tests = 0;
  int n_fail  = 0;

  fsk_top #(.WIN(WIN), .TOL(1), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data1 (data1),
    .data2 (data2),
    .f1    (f1),
    .f2    (f2),
    .q1    (q1),
    .q2    (q2)
  );

  // clk period 2; carriers offset by half a clk phase to avoid sampling races.
  always #1 clk = ~clk;
  initial begin #0.5; forever #2 f1 = ~f1; end
  initial begin #0.5; forever #4 f2 = ~f2; end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Clock edges since reset release; window k ends on edge k*WIN.
  int edges;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  // Reference modulator: two sync stages then the priority mux.
  logic [3:0] m1;
  logic [3:0] m2;
  logic       exp_mod;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1      <= '0;
      m2      <= '0;
      exp_mod <= 1'b0;
    end else begin
      m1      <= {data1, data2, f1, f2};
      m2      <= m1;
      exp_mod <= m2[3] ? m2[1] : (m2[2] ? m2[0] : 1'b0);
    end
  end

  typedef struct {
    int    widx;
    logic  q1;
    logic  q2;
    string tag;
  } exp_t;

  exp_t  sb[$];
  exp_t  cur_exp;
  logic  ev = 1'b0;

  // Monitor: expectation popped at its window end stays valid for that window.
  always @(negedge clk) begin : mon
    int widx;
    bit at_end;
    if (rst_n) begin
      widx   = edges / WIN;
      at_end = (edges % WIN) == 0;
      check("mod", {31'd0, dut.modulator_out}, {31'd0, exp_mod});
      check("excl", {31'd0, q1 & q2}, 32'd0);
      if (at_end) ev = 1'b0;
      if (sb.size() > 0 && sb[0].widx < widx) begin
        check("sb_missed", sb[0].widx, widx);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].widx == widx && (at_end || widx == 0)) begin
        cur_exp = sb.pop_front();
        ev      = 1'b1;
      end
      if (ev) begin
        check({cur_exp.tag, "_q1"}, {31'd0, q1}, {31'd0, cur_exp.q1});
        check({cur_exp.tag, "_q2"}, {31'd0, q2}, {31'd0, cur_exp.q2});
      end
    end
  end

  task automatic wait_edges(input int target);
    int guard = 0;
    while (edges < target && guard < 8 * WIN * 4) begin
      @(negedge clk);
      guard++;
    end
    check("timeout", {31'd0, edges >= target}, 32'd1);
  endtask

  // Apply data at a window boundary; result due at the first full window.
  task automatic run_case(input logic d1, input logic d2, input logic e1,
                          input logic e2, input string tag);
    int cur;
    if (edges == 0 || (edges % WIN) != 0) wait_edges((edges / WIN + 1) * WIN);
    cur   = edges / WIN;
    data1 = d1;
    data2 = d2;
    sb.push_back('{cur + 2, e1, e2, tag});
    wait_edges((cur + 3) * WIN);
  endtask

  initial begin
    #10000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    // Reset state
    #5;
    check("rst_q1", {31'd0, q1}, 32'd0);
    check("rst_q2", {31'd0, q2}, 32'd0);
    check("rst_mod", {31'd0, dut.modulator_out}, 32'd0);

    // f1 from the first window: q1 after the second window end
    data1 = 1'b1;
    sb.push_back('{0, 1'b0, 1'b0, "first_win"});
    sb.push_back('{2, 1'b1, 1'b0, "f1"});
    @(negedge clk);
    #0.2 rst_n = 1'b1;
    wait_edges(3 * WIN);

    run_case(1'b0, 1'b1, 1'b0, 1'b1, "f2");
    run_case(1'b1, 1'b1, 1'b1, 1'b0, "prio");
    run_case(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    run_case(1'b1, 1'b0, 1'b1, 1'b0, "f1b");

    // Asynchronous reset mid-window while data1=1
    wait_edges(edges + 7);
    #0.3 rst_n = 1'b0;
    #0.2;
    check("arst_q1", {31'd0, q1}, 32'd0);
    check("arst_q2", {31'd0, q2}, 32'd0);
    check("arst_mod", {31'd0, dut.modulator_out}, 32'd0);
    sb.push_back('{0, 1'b0, 1'b0, "rel_win"});
    sb.push_back('{2, 1'b1, 1'b0, "rel_f1"});
    @(negedge clk);
    #0.2 rst_n = 1'b1;
    wait_edges(3 * WIN);

    // Switch data1 -> data2 mid-window
    wait_edges(edges + 7);
    cur   = edges / WIN;
    data1 = 1'b0;
    data2 = 1'b1;
    sb.push_back('{cur + 2, 1'b0, 1'b1, "switch"});
    wait_edges((cur + 3) * WIN);

    @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
